// File: rtl/add_serial_4_pkg.sv
// svlib_arith_pkg: shared types and constants for the digit-serial arithmetic blocks
package svlib_arith_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} ser_add_state_t;
endpackage

// File: rtl/add_serial_4_if.sv
// add_serial_4_if: operand and result valid/ready handshakes for add_serial_4
interface add_serial_4_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (
        output in_valid, in0, in1, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, in0, in1, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/add_serial_4_cla_4.sv
// cla_4: 4-bit carry-lookahead slice; cin feeds every carry term so nibbles can chain
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p, g;
    logic [4:0] c;
    assign p = a ^ b;
    assign g = a & b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

// File: rtl/add_serial_4.sv
// add_serial_4: digit-serial adder, one nibble per clock through a shared cla_4 slice
module add_serial_4
    import svlib_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    add_serial_4_if.slave bus
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if (WIDTH % NIB_W != 0 || WIDTH < NIB_W) begin : g_bad_width
        $error("add_serial_4: WIDTH must be a multiple of 4 and at least 4");
    end

    ser_add_state_t   state, nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt, res_q;
    logic             carry_q, res_c;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       nib_s;
    logic             nib_c, last;

    cla_4 u_cla (
        .a   (a_q[NIB_W-1:0]),
        .b   (b_q[NIB_W-1:0]),
        .cin (carry_q),
        .s   (nib_s),
        .cout(nib_c)
    );

    // Nibble sums enter from the top so the first nibble ends up in the LSBs.
    if (WIDTH == NIB_W) begin : g_one
        assign sum_nxt = nib_s;
    end else begin : g_many
        assign sum_nxt = {nib_s, sum_q[WIDTH-1:NIB_W]};
    end

    assign last = cnt_q == CW'(NIB - 1);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) nxt = RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            res_c   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.in_valid) begin
                a_q     <= bus.in0;
                b_q     <= bus.in1;
                carry_q <= bus.cin;
                cnt_q   <= '0;
            end else if (state == RUN) begin
                sum_q   <= sum_nxt;
                a_q     <= a_q >> NIB_W;
                b_q     <= b_q >> NIB_W;
                carry_q <= nib_c;
                cnt_q   <= cnt_q + CW'(1);
                // Separate result register keeps sum/cout stable while the next op runs.
                if (last) begin
                    res_q <= sum_nxt;
                    res_c <= nib_c;
                end
            end
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = res_q;
    assign bus.cout      = res_c;
endmodule

// File: tb/tb_add_serial_4.sv
// tb_add_serial_4: scoreboard bench for add_serial_4 at WIDTH 16, 4 and 32
module tb_add_serial_4;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   got;
    logic [16:0] sb16[$];
    logic [4:0]  sb4[$];
    logic [32:0] sb32[$];

    always #5 clk = ~clk;

    add_serial_4_if #(.WIDTH(16)) i16 ();
    add_serial_4_if #(.WIDTH(4))  i4 ();
    add_serial_4_if #(.WIDTH(32)) i32 ();

    add_serial_4 #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));
    add_serial_4 #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(i4));
    add_serial_4 #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Call on a negedge with the block idle; returns on the negedge where out_valid is seen.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, output int n);
        i16.in0 = a;
        i16.in1 = b;
        i16.cin = c;
        i16.in_valid = 1'b1;
        sb16.push_back(17'(a) + 17'(b) + 17'(c));
        @(negedge clk);
        i16.in_valid = 1'b0;
        i16.in0 = 16'hFFFF;
        i16.in1 = 16'hFFFF;
        i16.cin = 1'b1;
        n = 0;
        while (!i16.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop16(input string tag);
        chk(tag, 64'({i16.cout, i16.sum}), sb16.size() > 0 ? 64'(sb16.pop_front()) : '1);
    endtask

    initial begin
        rst_n = 1'b1;
        {i16.in_valid, i16.cin, i16.out_ready, i16.in0, i16.in1} = '0;
        {i4.in_valid, i4.cin, i4.out_ready, i4.in0, i4.in1} = '0;
        {i32.in_valid, i32.cin, i32.out_ready, i32.in0, i32.in1} = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(i16.in_ready), 1);
        chk("rst_out_valid", 64'(i16.out_valid), 0);
        chk("rst_sum", 64'({i16.cout, i16.sum}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        i16.out_ready = 1'b1;
        run16(16'h1234, 16'h4321, 1'b0, lat);
        chk("basic_lat", 64'(lat), 4);
        pop16("basic_res");
        @(negedge clk);

        run16(16'hFFFF, 16'h0000, 1'b1, lat);
        chk("ripple_lat", 64'(lat), 4);
        pop16("ripple_res");
        @(negedge clk);

        i16.out_ready = 1'b0;
        run16(16'h0FFF, 16'h0001, 1'b0, lat);
        pop16("hold_res");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i16.in_valid = (k == 1);
            i16.in0 = 16'hAAAA;
            chk("hold_valid", 64'(i16.out_valid), 1);
            chk("hold_sum", 64'({i16.cout, i16.sum}), 64'h1000);
            chk("hold_in_ready", 64'(i16.in_ready), 0);
        end
        i16.in_valid = 1'b0;
        i16.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(i16.in_ready), 1);
        chk("release_out_valid", 64'(i16.out_valid), 0);
        run16(16'h0001, 16'h0002, 1'b0, lat);
        chk("release_lat", 64'(lat), 4);
        pop16("release_res");
        @(negedge clk);
        chk("no_dup_valid", 64'(i16.out_valid), 0);

        i16.in0 = 16'h7777;
        i16.in1 = 16'h1111;
        i16.in_valid = 1'b1;
        @(negedge clk);
        i16.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(i16.out_valid), 0);
        chk("abort_in_ready", 64'(i16.in_ready), 1);
        chk("abort_sum", 64'({i16.cout, i16.sum}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run16(16'h0001, 16'h0001, 1'b0, lat);
        chk("after_abort_lat", 64'(lat), 4);
        pop16("after_abort_res");
        chk("sb16_empty", 64'(sb16.size()), 0);

        i4.out_ready = 1'b1;
        i4.in0 = 4'hF;
        i4.in1 = 4'hF;
        i4.cin = 1'b1;
        i4.in_valid = 1'b1;
        sb4.push_back(5'h1F);
        @(negedge clk);
        i4.in_valid = 1'b0;
        lat = 0;
        while (!i4.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_lat", 64'(lat), 1);
        chk("w4_res", 64'({i4.cout, i4.sum}), sb4.size() > 0 ? 64'(sb4.pop_front()) : '1);

        got = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [31:0] a, b;
                    logic        c;
                    int          w;
                    @(negedge clk);
                    a = $urandom;
                    b = $urandom;
                    c = 1'($urandom_range(0, 1));
                    i32.in0 = a;
                    i32.in1 = b;
                    i32.cin = c;
                    i32.in_valid = 1'b1;
                    w = 0;
                    while (!i32.in_ready && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 100) chk("rand_accept_timeout", 64'(w), 0);
                    sb32.push_back(33'(a) + 33'(b) + 33'(c));
                end
                @(negedge clk);
                i32.in_valid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 60000 && got < 1000; cyc++) begin
                    @(negedge clk);
                    i32.out_ready = 1'($urandom_range(0, 1));
                    if (i32.out_valid && i32.out_ready) begin
                        chk("rand_res", 64'({i32.cout, i32.sum}),
                            sb32.size() > 0 ? 64'(sb32.pop_front()) : '1);
                        got++;
                    end
                end
            end
        join
        repeat (20) @(negedge clk);
        chk("rand_count", 64'(got), 1000);
        chk("rand_left", 64'(sb32.size()), 0);
        chk("rand_no_extra", 64'(i32.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
